// File: rtl/flex_step_counter.sv
// ----------------------------------------------------------------------------
// flex_step_counter
//
// Purpose:
//   General-purpose step counter used for the RC4 i/j index and the Sobel
//   pixel/row sequencing datapaths. It counts up or down by a programmable
//   step between start_val and rollover_val. When a step would cross a bound,
//   the counter either wraps to the opposite bound or saturates at the bound
//   it was approaching. A synchronous clear and a synchronous load are also
//   provided. All outputs are registered.
//
//   With start_val = 1, step = 1, count up and wrap mode, it behaves as a
//   basic 1..N rollover counter.
//
// Parameters:
//   NUM_CNT_BITS  width of count_out, load_val, start_val and rollover_val
//   STEP_BITS     width of step (must be <= NUM_CNT_BITS)
//
// Ports:
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous reset, active low
//   clear          in   synchronous clear (highest priority)
//   load           in   synchronous load of load_val
//   load_val       in   value used by load
//   count_enable   in   advance one step this cycle
//   count_down     in   0 = count up, 1 = count down
//   saturate       in   0 = wrap at bounds, 1 = clamp at bounds
//   step           in   increment/decrement magnitude
//   start_val      in   lower bound and up-wrap target
//   rollover_val   in   upper bound and down-wrap target
//   count_out      out  current count (registered)
//   rollover_flag  out  count_out equals the terminal value (registered)
//   wrap_pulse     out  one-cycle pulse in the cycle after a wrap (registered)
// ----------------------------------------------------------------------------
module flex_step_counter #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned STEP_BITS    = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    count_down,
  input  logic                    saturate,
  input  logic [STEP_BITS-1:0]    step,
  input  logic [NUM_CNT_BITS-1:0] start_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    wrap_pulse
);

  // One extra bit so that sums and bound comparisons never overflow silently.
  localparam int unsigned W = NUM_CNT_BITS + 1;

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;

  // Widened operands.
  logic [W-1:0] cur_w;
  logic [W-1:0] step_w;
  logic [W-1:0] start_w;
  logic [W-1:0] roll_w;
  logic [W-1:0] up_sum;
  logic [W-1:0] down_lim;

  // Result of an enabled step, before priority muxing.
  logic [NUM_CNT_BITS-1:0] step_next;
  logic                    step_wrap;

  // Terminal value depends on the direction currently requested.
  logic [NUM_CNT_BITS-1:0] terminal;

  logic degenerate;

  always_comb begin
    cur_w    = W'(count_q);
    step_w   = W'(step);
    start_w  = W'(start_val);
    roll_w   = W'(rollover_val);
    up_sum   = cur_w + step_w;
    down_lim = start_w + step_w;
    terminal = count_down ? start_val : rollover_val;
    // Inverted bounds: there is no valid range, so every step parks on start_val.
    degenerate = (start_val > rollover_val);
  end

  // Next value for an enabled step.
  always_comb begin
    step_next = count_q;
    step_wrap = 1'b0;
    if (degenerate) begin
      step_next = start_val;
    end else if (step == '0) begin
      // A zero step holds even when the count sits outside the bounds.
      step_next = count_q;
    end else if (!count_down) begin
      if (up_sum <= roll_w) begin
        step_next = NUM_CNT_BITS'(up_sum);
      end else if (saturate) begin
        step_next = rollover_val;
      end else begin
        step_next = start_val;
        step_wrap = 1'b1;
      end
    end else begin
      if (cur_w >= down_lim) begin
        // Guarded by the comparison above, so this cannot underflow.
        step_next = NUM_CNT_BITS'(cur_w - step_w);
      end else if (saturate) begin
        step_next = start_val;
      end else begin
        step_next = rollover_val;
        step_wrap = 1'b1;
      end
    end
  end

  // Priority: clear > load > count_enable > hold.
  always_comb begin
    count_d = count_q;
    flag_d  = flag_q;
    pulse_d = 1'b0;
    if (clear) begin
      count_d = '0;
      flag_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      flag_d  = (load_val == terminal);
    end else if (count_enable) begin
      count_d = step_next;
      flag_d  = (step_next == terminal);
      pulse_d = step_wrap;
    end
    // Hold: the flag is deliberately not re-evaluated against changed bounds.
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;

endmodule

// File: tb/tb_flex_step_counter.sv
// ----------------------------------------------------------------------------
// tb_flex_step_counter
//
// Self-checking bench for flex_step_counter (8-bit count, 4-bit step).
// Directed scenarios followed by randomized traffic, all compared against a
// behavioural model computed with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_flex_step_counter;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic       count_enable;
  logic       count_down;
  logic       saturate;
  logic [3:0] step;
  logic [7:0] start_val;
  logic [7:0] rollover_val;
  logic [7:0] count_out;
  logic       rollover_flag;
  logic       wrap_pulse;

  int n_pass;
  int n_total;

  // Model state.
  int m_count;
  bit m_flag;
  bit m_pulse;

  flex_step_counter #(
    .NUM_CNT_BITS(8),
    .STEP_BITS   (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .count_down   (count_down),
    .saturate     (saturate),
    .step         (step),
    .start_val    (start_val),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .wrap_pulse   (wrap_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  function automatic void model_update();
    int term, s, nc;
    bit np;
    term = count_down ? int'(start_val) : int'(rollover_val);
    if (clear) begin
      m_count = 0; m_flag = 0; m_pulse = 0;
    end else if (load) begin
      m_count = int'(load_val);
      m_flag  = (m_count == term);
      m_pulse = 0;
    end else if (count_enable) begin
      np = 0;
      if (int'(start_val) > int'(rollover_val)) begin
        nc = int'(start_val);
      end else if (step == 0) begin
        nc = m_count;
      end else if (!count_down) begin
        s = m_count + int'(step);
        if (s <= int'(rollover_val)) nc = s;
        else if (saturate) nc = int'(rollover_val);
        else begin nc = int'(start_val); np = 1; end
      end else begin
        if (m_count >= int'(start_val) + int'(step)) nc = m_count - int'(step);
        else if (saturate) nc = int'(start_val);
        else begin nc = int'(rollover_val); np = 1; end
      end
      m_count = nc;
      m_flag  = (nc == term);
      m_pulse = np;
    end else begin
      m_pulse = 0;
    end
  endfunction

  // One clock: update model, let the edge happen, compare away from the edge.
  task automatic tick(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check({tag, "_count"}, 32'(count_out), 32'(m_count));
    check({tag, "_flag"}, 32'(rollover_flag), 32'(m_flag));
    check({tag, "_pulse"}, 32'(wrap_pulse), 32'(m_pulse));
  endtask

  // Async reset asserted between edges; outputs must clear immediately.
  task automatic mid_reset(input string tag);
    #2;
    n_rst = 1'b0;
    #1;
    check({tag, "_rst_count"}, 32'(count_out), 32'd0);
    check({tag, "_rst_flag"}, 32'(rollover_flag), 32'd0);
    check({tag, "_rst_pulse"}, 32'(wrap_pulse), 32'd0);
    m_count = 0; m_flag = 0; m_pulse = 0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    int t4_exp[4];
    n_pass = 0;
    n_total = 0;
    m_count = 0; m_flag = 0; m_pulse = 0;

    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = 8'd0;
    count_enable = 1'b0; count_down = 1'b0; saturate = 1'b0; step = 4'd1;
    start_val = 8'd1; rollover_val = 8'd5;

    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count_out), 32'd0);
    check("reset_flag", 32'(rollover_flag), 32'd0);
    check("reset_pulse", 32'(wrap_pulse), 32'd0);
    n_rst = 1'b1;

    // 1: basic 1..5 rollover counter from reset.
    count_enable = 1'b1;
    for (int i = 0; i < 7; i++) tick("t1");
    check("t1_lit_count", 32'(count_out), 32'd2);

    // 2: step 3 up to 10, wrap to 0.
    clear = 1'b1; tick("t2_clr"); clear = 1'b0;
    start_val = 8'd0; rollover_val = 8'd10; step = 4'd3;
    for (int i = 0; i < 4; i++) tick("t2");
    check("t2_lit_count", 32'(count_out), 32'd0);
    check("t2_lit_pulse", 32'(wrap_pulse), 32'd1);
    check("t2_lit_flag", 32'(rollover_flag), 32'd0);

    // 3: saturate at 10.
    clear = 1'b1; tick("t3_clr"); clear = 1'b0;
    step = 4'd4; saturate = 1'b1;
    for (int i = 0; i < 4; i++) tick("t3");
    check("t3_lit_count", 32'(count_out), 32'd10);
    check("t3_lit_flag", 32'(rollover_flag), 32'd1);
    check("t3_lit_pulse", 32'(wrap_pulse), 32'd0);

    // 4: down by 2 between 2 and 9 from a load of 8.
    saturate = 1'b0; start_val = 8'd2; rollover_val = 8'd9; step = 4'd2;
    count_down = 1'b1; count_enable = 1'b0;
    load = 1'b1; load_val = 8'd8; tick("t4_load"); load = 1'b0;
    check("t4_lit_load", 32'(count_out), 32'd8);
    count_enable = 1'b1;
    t4_exp = '{6, 4, 2, 9};
    for (int i = 0; i < 4; i++) begin
      tick("t4");
      check("t4_lit_seq", 32'(count_out), 32'(t4_exp[i]));
    end
    check("t4_lit_pulse", 32'(wrap_pulse), 32'd1);
    check("t4_lit_flag", 32'(rollover_flag), 32'd0);

    // 5: priority and async reset.
    clear = 1'b1; load = 1'b1; load_val = 8'd7; tick("t5_all");
    check("t5_lit_clear", 32'(count_out), 32'd0);
    clear = 1'b0; tick("t5_ld_en");
    check("t5_lit_load", 32'(count_out), 32'd7);
    load = 1'b0; tick("t5_run");
    mid_reset("t5");

    // 6: top of the 8-bit range.
    count_down = 1'b0; start_val = 8'd7; rollover_val = 8'd255; step = 4'd3;
    load = 1'b1; load_val = 8'd254; tick("t6_load"); load = 1'b0;
    tick("t6_wrap");
    check("t6_lit_wrap", 32'(count_out), 32'd7);
    check("t6_lit_wpulse", 32'(wrap_pulse), 32'd1);
    saturate = 1'b1;
    load = 1'b1; tick("t6_load2"); load = 1'b0;
    tick("t6_sat");
    check("t6_lit_sat", 32'(count_out), 32'd255);
    check("t6_lit_sflag", 32'(rollover_flag), 32'd1);

    // Degenerate bounds and zero step.
    start_val = 8'd40; rollover_val = 8'd20; tick("degen");
    start_val = 8'd3; rollover_val = 8'd12; step = 4'd0; tick("zero_step");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      clear        = ($urandom_range(0, 31) == 0);
      load         = ($urandom_range(0, 15) == 0);
      load_val     = 8'($urandom_range(0, 255));
      count_enable = ($urandom_range(0, 3) != 0);
      count_down   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 7) == 0) saturate = ~saturate;
      if ($urandom_range(0, 7) == 0) step = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        start_val    = 8'($urandom_range(0, 60));
        rollover_val = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                                   : 8'($urandom_range(61, 255));
      end
      tick("rand");
      if ($urandom_range(0, 99) == 0) mid_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
